// File: rtl/register_file_if.sv
// Register file port bundle: decode read addresses, writeback write port,
// fetch-supplied R15 value, and the two operand read outputs.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wr;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] r15;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    modport master (
        output wr, ra1, ra2, wa, wd, r15,
        input  rd1, rd2
    );

    modport slave (
        input  wr, ra1, ra2, wa, wd, r15,
        output rd1, rd2
    );
endinterface

// File: rtl/register_file.sv
// Scalar register file: R0..R14 storage, R15 aliased to the external PC value.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  bus
);
    localparam int NREG = (2 ** ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(NREG);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              we;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;

    assign we = bus.wr && (bus.wa != TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we && bus.wa == ADDR_W'(i)) regs_q[i] <= bus.wd;
            end
        end
    end

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.ra1 == ADDR_W'(i)) rd1_d = regs_q[i];
            if (bus.ra2 == ADDR_W'(i)) rd2_d = regs_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        // we already excludes address 15, so the PC alias is never forwarded
        if (we && bus.ra1 == bus.wa) rd1_d = bus.wd;
        if (we && bus.ra2 == bus.wa) rd2_d = bus.wd;
`endif
        if (bus.ra1 == TOP) rd1_d = bus.r15;
        if (bus.ra2 == TOP) rd2_d = bus.r15;
    end

    assign bus.rd1 = rd1_d;
    assign bus.rd2 = rd2_d;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed plan plus random traffic
// compared against an array model of the architectural registers.
module tb_register_file;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] m [15];

    register_file_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    register_file #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        logic [31:0] v;
        if (a == 4'd15) return bus.r15;
        v = m[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.wr && bus.wa != 4'd15 && bus.wa == a && rst_n) v = bus.wd;
`endif
        return v;
    endfunction

    task automatic edge_commit();
        @(posedge clk);
        if (rst_n && bus.wr && bus.wa != 4'd15) m[bus.wa] = bus.wd;
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 15; i++) begin
            bus.ra2 = 4'(i);
            #1;
            check(tag, bus.rd2, m[i]);
        end
    endtask

    initial begin
        bus.wr = 0; bus.ra1 = 0; bus.ra2 = 0;
        bus.wa = 0; bus.wd = 0; bus.r15 = 32'h4C;
        for (int i = 0; i < 15; i++) m[i] = '0;
        #3 rst_n = 0;
        #3 rst_n = 1;
        #1;
        check_all("reset_zero");
        bus.ra1 = 4'd15; #1;
        check("reset_r15", bus.rd1, 32'h4C);

        clk_en = 1;
        @(negedge clk);
        bus.wr = 1; bus.wa = 4; bus.wd = 32'h4;
        edge_commit();
        bus.wr = 0; bus.ra1 = 4; bus.ra2 = 0; #1;
        check("wr4_rd1", bus.rd1, 32'h4);
        check("wr4_rd2", bus.rd2, 32'h0);

        @(negedge clk);
        bus.wr = 1; bus.wa = 3; bus.wd = 32'hF;
        edge_commit();
        bus.wr = 0; bus.ra1 = 4; bus.ra2 = 3; #1;
        check("dual_rd1", bus.rd1, 32'h4);
        check("dual_rd2", bus.rd2, 32'hF);

        bus.ra1 = 15; #1;
        check("r15_a", bus.rd1, 32'h4C);
        bus.r15 = 32'h50; #1;
        check("r15_b", bus.rd1, 32'h50);
        @(negedge clk);
        bus.wr = 1; bus.wa = 15; bus.wd = 32'hDEAD; #1;
        check("r15_nobyp", bus.rd1, 32'h50);
        edge_commit();
        bus.wr = 0; #1;
        check("r15_after", bus.rd1, 32'h50);
        check_all("wr15_drop");

        @(negedge clk);
        bus.wr = 0; bus.wa = 4; bus.wd = 32'h99;
        edge_commit();
        bus.ra1 = 4; #1;
        check("wr0_hold", bus.rd1, 32'h4);
        @(negedge clk);
        bus.wr = 1; bus.wa = 4; bus.wd = 32'h77; #1;
`ifdef REGFILE_BYPASS_EN
        check("same_pre", bus.rd1, 32'h77);
`else
        check("same_pre", bus.rd1, 32'h4);
`endif
        edge_commit();
        bus.wr = 0; #1;
        check("same_post", bus.rd1, 32'h77);

        @(negedge clk);
        bus.ra1 = 3; #1;
        check("pre_rst", bus.rd1, 32'hF);
        rst_n = 0;
        for (int i = 0; i < 15; i++) m[i] = '0;
        #1;
        check("mid_rst", bus.rd1, 32'h0);
        bus.wr = 1; bus.wa = 3; bus.wd = 32'h55;
        edge_commit();
        check("rst_wr_lost", bus.rd1, 32'h0);
        @(negedge clk);
        bus.wr = 0;
        rst_n = 1;
        #1;
        check_all("post_rst");

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            bus.wr  = 1'($urandom);
            bus.wa  = 4'($urandom);
            bus.wd  = $urandom;
            bus.r15 = $urandom;
            bus.ra1 = 4'($urandom);
            bus.ra2 = ($urandom_range(0, 3) == 0) ? bus.wa : 4'($urandom);
            #1;
            check("rnd_rd1", bus.rd1, model_rd(bus.ra1));
            check("rnd_rd2", bus.rd2, model_rd(bus.ra2));
            edge_commit();
        end
        bus.wr = 0;
        check_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_file.md
# register_file

Architectural general-purpose register file for the processor's scalar datapath: fifteen 32-bit writable registers (R0–R14) plus a read-only R15 view driven from outside (program-counter value supplied by the fetch stage). Two asynchronous read ports feed the operand path, and one synchronous write port is driven by writeback. Sits between decode (read addresses) and writeback (write address/data).

## Interface
Parameters:
- DATA_W, 32, register and port data width
- ADDR_W, 4, register address width; register count is 2**ADDR_W, and the top address is the R15 alias

Ports:
- clk  input  1  clock; all state changes on rising edge. One clock domain.
- rst_n  input  1  reset, asynchronous, active-low
- wr  input  1  write enable
- ra1  input  ADDR_W  read address, port 1
- ra2  input  ADDR_W  read address, port 2
- wa  input  ADDR_W  write address
- wd  input  DATA_W  write data
- r15  input  DATA_W  value returned for reads of address 15 (PC+8 from fetch)
- rd1  output  DATA_W  read data, port 1
- rd2  output  DATA_W  read data, port 2

## Operation
- Storage: registers R0..R14, DATA_W bits each. R0 is an ordinary writable register, not hard-wired to zero.
- Read: rd1 = (ra1 == 15) ? r15 : R[ra1]. rd2 is formed the same way from ra2. Reads are purely combinational and both ports are fully independent. Both ports may read the same address.
- Write: on rising clk with rst_n=1 and wr=1, R[wa] <= wd when wa != 15.
- Write to address 15: no register changes and the write is silently dropped. R15 is only the r15 input.
- wr=0: no register changes, whatever wa and wd hold.
- Reset: while rst_n=0, R0..R14 = 0 immediately, regardless of clk, and writes are ignored. rd1 and rd2 follow the read rule, so they read 0 for addresses 0–14 and r15 for address 15.

## Timing
- Read latency: 0 cycles, combinational from ra1, ra2, r15 and register state.
- Write latency: 1 edge. The new value is visible on rd1 and rd2 after the rising edge that captures it.
- Same-cycle read and write of one address: without bypass, the read returns the old value until the edge. Bypass behaviour is under Configuration.
- rst_n assertion mid-cycle clears the registers asynchronously. A write on the same edge on which rst_n is still low is lost.
- The first write is accepted on the first rising edge after rst_n is high.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding is enabled. When wr=1, wa != 15 and rdN's address == wa, rdN = wd combinationally in the same cycle. Register state still updates only at the edge. Address 15 is never bypassed.
- REGFILE_BYPASS_EN undefined: there is no forwarding, and reads always reflect stored state, as described in Timing.

## Test plan
- Reset: pulse rst_n low with no clock, then read all addresses 0–14 -> every read is 0. Read address 15 with r15=0x4C -> reads 0x4C.
- Basic write/read: wr=1, wa=4, wd=0x4, rising edge, then ra1=4, ra2=0 -> rd1=0x4 and rd2=0.
- Second write and dual read: wa=3, wd=0xF, edge, then ra1=4, ra2=3 -> rd1=0x4 and rd2=0xF.
- R15 alias: r15=0x4C, ra1=15 -> rd1=0x4C. Change r15 to 0x50 -> rd1 becomes 0x50 with no edge. Then wr=1, wa=15, wd=0xDEAD, edge -> rd1 still reads r15 and R0..R14 are unchanged.
- Write enable and same-address read: wr=0, wa=4, wd=0x99, edge -> R4 stays 0x4. Then wr=1, wa=4, wd=0x77, ra1=4 before the edge -> rd1=0x4 without the macro, 0x77 with REGFILE_BYPASS_EN. After the edge, rd1=0x77 in both builds.
- Reset mid-operation: R3=0xF, assert rst_n low between edges -> rd for address 3 is 0 immediately. A wr=1 edge during reset leaves R3 at 0.
